// File: rtl/mux4_scan_sampler.sv
// -----------------------------------------------------------------------------
// mux4_scan_sampler
//   Sequencer wrapped around a gate-level 4->1 mux. Steps the mux select lines
//   through channels 0..3, waits SETTLE_CYCLES idle cycles after every select
//   change so the mux output has propagated, samples z_in, and packs the four
//   samples into a 4-bit word delivered on a valid/ready handshake. Supports
//   one-shot scans (start) and back-to-back scans (continuous at handshake).
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request a scan, honoured only while idle
//   continuous  in   sampled at the word handshake: 1 = start next scan at once
//   sel[1:0]    out  select lines to the mux
//   z_in        in   mux output
//   word_out    out  captured word, bit k = sample taken with sel=k
//   word_valid  out  word_out holds an unconsumed word
//   word_ready  in   consumer accepts word_out
//   busy        out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module mux4_scan_sampler #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       continuous,
    output logic [1:0] sel,
    input  logic       z_in,
    output logic [3:0] word_out,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       busy
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t     r_state, w_state;
    logic [1:0] r_sel, w_sel;
    logic [3:0] r_cnt, w_cnt;
    logic [2:0] r_shadow, w_shadow;
    logic [3:0] r_word, w_word;
    logic       r_valid, w_valid;
    logic       r_busy, w_busy;

    // State and output registers; reset drops any partial or pending word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sel    <= 2'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 3'd0;
            r_word   <= 4'd0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_sel    <= w_sel;
            r_cnt    <= w_cnt;
            r_shadow <= w_shadow;
            r_word   <= w_word;
            r_valid  <= w_valid;
            r_busy   <= w_busy;
        end
    end

    // Next-state logic: scan sequencing, settle countdown and handshake.
    always_comb begin
        w_state  = r_state;
        w_sel    = r_sel;
        w_cnt    = r_cnt;
        w_shadow = r_shadow;
        w_word   = r_word;
        w_valid  = r_valid;

        case (r_state)
            ST_IDLE: begin
                w_sel = 2'd0;
                if (start) begin
                    w_cnt   = SETTLE_INIT;
                    w_state = ST_SETTLE;
                end else begin
                    w_cnt   = r_cnt;
                end
            end

            ST_SETTLE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else if (r_sel != 2'd3) begin
                    // Channels 0..2 go to the shadow; channel 3 completes the word.
                    case (r_sel)
                        2'd0:    w_shadow[0] = z_in;
                        2'd1:    w_shadow[1] = z_in;
                        2'd2:    w_shadow[2] = z_in;
                        default: w_shadow    = r_shadow;
                    endcase
                    w_sel = r_sel + 2'd1;
                    w_cnt = SETTLE_INIT;
                end else begin
                    w_word  = {z_in, r_shadow};
                    w_valid = 1'b1;
                    w_state = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (word_ready) begin
                    w_valid = 1'b0;
                    w_sel   = 2'd0;
                    if (continuous) begin
                        w_cnt   = SETTLE_INIT;
                        w_state = ST_SETTLE;
                    end else begin
                        w_state = ST_IDLE;
                    end
                end else begin
                    w_valid = r_valid;
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_sel   = 2'd0;
                w_cnt   = 4'd0;
                w_valid = 1'b0;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign sel        = r_sel;
    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign busy       = r_busy;

endmodule
